arm_pipelined_cond_unit: RTL and testbench

//  Execute-stage conditional-execution unit, directly downstream of the ALU.
//  - Holds the architectural NZCV flags register and tests the instruction's cond field against it.
//  - Updates the flags from the ALU flag bus and gates the write/branch controls.
//  - Registers the gated controls plus the ALU result into the Execute->Memory pipeline stage.

---
 rtl/arm_pipelined_pkg.sv | 30 +++
 rtl/arm_pipelined_cond_check.sv | 41 ++++
 rtl/arm_pipelined_cond_unit.sv | 96 +++++++++
 tb/tb_arm_pipelined_cond_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipelined_pkg.sv
// Shared definitions for the pipelined ARM execute/memory datapath.
package arm_pipelined_pkg;

  // Instruction condition field encodings.
  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } en_Cond;

  // Bit positions inside the NZCV flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/arm_pipelined_cond_check.sv
// Combinational test of an instruction cond field against the NZCV flags.
module arm_pipelined_cond_check
  import arm_pipelined_pkg::*;
(
  input  logic [3:0] i_Cond,
  input  logic [3:0] i_Flags,
  output logic       o_Pass
);

  logic n, z, c, v;

  assign n = i_Flags[FLAG_N];
  assign z = i_Flags[FLAG_Z];
  assign c = i_Flags[FLAG_C];
  assign v = i_Flags[FLAG_V];

  // Decode the condition code into a pass/fail bit; NV never executes.
  always_comb begin
    o_Pass = 1'b0;
    case (en_Cond'(i_Cond))
      EQ:      o_Pass = z;
      NE:      o_Pass = ~z;
      CS:      o_Pass = c;
      CC:      o_Pass = ~c;
      MI:      o_Pass = n;
      PL:      o_Pass = ~n;
      VS:      o_Pass = v;
      VC:      o_Pass = ~v;
      HI:      o_Pass = c & ~z;
      LS:      o_Pass = ~c | z;
      GE:      o_Pass = (n == v);
      LT:      o_Pass = (n != v);
      GT:      o_Pass = ~z & (n == v);
      LE:      o_Pass = z | (n != v);
      AL:      o_Pass = 1'b1;
      NV:      o_Pass = 1'b0;
      default: o_Pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_pipelined_cond_unit.sv
// Execute-stage conditional-execution unit: NZCV flags register, condition
// gating of write/branch controls, and the Execute->Memory pipeline register.
module arm_pipelined_cond_unit
  import arm_pipelined_pkg::*;
#(
  parameter int BusWidth = 32,
  parameter int RegAddrW = 4
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic                i_Stall_M,
  input  logic                i_Flush_M,
  input  logic                i_Valid_E,
  input  logic [3:0]          i_Cond_E,
  input  logic [3:0]          i_ALU_Flags,
  input  logic [1:0]          i_FlagWrite_E,
  input  logic                i_PCSrc_E,
  input  logic                i_RegWrite_E,
  input  logic                i_MemWrite_E,
  input  logic [BusWidth-1:0] i_ALU_Result,
  input  logic [BusWidth-1:0] i_WriteData_E,
  input  logic [RegAddrW-1:0] i_WA3_E,
  output logic                o_CondEx_E,
  output logic                o_PCSrc_E,
  output logic [3:0]          o_Flags,
  output logic                o_RegWrite_M,
  output logic                o_MemWrite_M,
  output logic [BusWidth-1:0] o_ALUResult_M,
  output logic [BusWidth-1:0] o_WriteData_M,
  output logic [RegAddrW-1:0] o_WA3_M
);

  logic                cond_pass;
  logic [3:0]          flags_p1;
  logic                reg_write_p1;
  logic                mem_write_p1;
  logic [BusWidth-1:0] alu_result_p1;
  logic [BusWidth-1:0] write_data_p1;
  logic [RegAddrW-1:0] wa3_p1;

  // Conditions are always tested against the registered flags, so an
  // instruction's own flag update cannot influence its own execution.
  arm_pipelined_cond_check u_cond_check (
    .i_Cond  (i_Cond_E),
    .i_Flags (flags_p1),
    .o_Pass  (cond_pass)
  );

  // ---- Execute stage: combinational gating ----
  assign o_CondEx_E = cond_pass & i_Valid_E;
  assign o_PCSrc_E  = i_PCSrc_E & o_CondEx_E;

  // Architectural flags: N/Z and C/V halves update independently, only for
  // executed instructions, and are frozen while the M stage is stalled.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      flags_p1 <= 4'b0000;
    end else if (!i_Stall_M && o_CondEx_E) begin
      if (i_FlagWrite_E[1]) begin
        flags_p1[FLAG_N] <= i_ALU_Flags[FLAG_N];
        flags_p1[FLAG_Z] <= i_ALU_Flags[FLAG_Z];
      end
      if (i_FlagWrite_E[0]) begin
        flags_p1[FLAG_C] <= i_ALU_Flags[FLAG_C];
        flags_p1[FLAG_V] <= i_ALU_Flags[FLAG_V];
      end
    end
  end

  // ---- Execute -> Memory boundary ----
  // M-stage register with priority reset > flush > stall > load; a flush
  // inserts a zeroed bubble even while stalled.
  always_ff @(posedge i_CLK) begin
    if (i_RST || i_Flush_M) begin
      reg_write_p1  <= 1'b0;
      mem_write_p1  <= 1'b0;
      alu_result_p1 <= '0;
      write_data_p1 <= '0;
      wa3_p1        <= '0;
    end else if (!i_Stall_M) begin
      reg_write_p1  <= i_RegWrite_E & o_CondEx_E;
      mem_write_p1  <= i_MemWrite_E & o_CondEx_E;
      alu_result_p1 <= i_ALU_Result;
      write_data_p1 <= i_WriteData_E;
      wa3_p1        <= i_WA3_E;
    end
  end

  assign o_Flags       = flags_p1;
  assign o_RegWrite_M  = reg_write_p1;
  assign o_MemWrite_M  = mem_write_p1;
  assign o_ALUResult_M = alu_result_p1;
  assign o_WriteData_M = write_data_p1;
  assign o_WA3_M       = wa3_p1;

endmodule

// File: tb/tb_arm_pipelined_cond_unit.sv
// Self-checking bench for arm_pipelined_cond_unit: directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_arm_pipelined_cond_unit;

  localparam int BW = 32;
  localparam int AW = 4;

  logic          i_CLK = 1'b0;
  logic          i_RST, i_Stall_M, i_Flush_M, i_Valid_E;
  logic [3:0]    i_Cond_E, i_ALU_Flags;
  logic [1:0]    i_FlagWrite_E;
  logic          i_PCSrc_E, i_RegWrite_E, i_MemWrite_E;
  logic [BW-1:0] i_ALU_Result, i_WriteData_E;
  logic [AW-1:0] i_WA3_E;
  logic          o_CondEx_E, o_PCSrc_E, o_RegWrite_M, o_MemWrite_M;
  logic [3:0]    o_Flags;
  logic [BW-1:0] o_ALUResult_M, o_WriteData_M;
  logic [AW-1:0] o_WA3_M;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [3:0]    m_flags;
  logic          m_rw, m_mw;
  logic [BW-1:0] m_res, m_wd;
  logic [AW-1:0] m_wa3;

  arm_pipelined_cond_unit #(.BusWidth(BW), .RegAddrW(AW)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_Stall_M(i_Stall_M), .i_Flush_M(i_Flush_M),
    .i_Valid_E(i_Valid_E), .i_Cond_E(i_Cond_E), .i_ALU_Flags(i_ALU_Flags),
    .i_FlagWrite_E(i_FlagWrite_E), .i_PCSrc_E(i_PCSrc_E), .i_RegWrite_E(i_RegWrite_E),
    .i_MemWrite_E(i_MemWrite_E), .i_ALU_Result(i_ALU_Result), .i_WriteData_E(i_WriteData_E),
    .i_WA3_E(i_WA3_E), .o_CondEx_E(o_CondEx_E), .o_PCSrc_E(o_PCSrc_E), .o_Flags(o_Flags),
    .o_RegWrite_M(o_RegWrite_M), .o_MemWrite_M(o_MemWrite_M), .o_ALUResult_M(o_ALUResult_M),
    .o_WriteData_M(o_WriteData_M), .o_WA3_M(o_WA3_M)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic check_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ARM conditions: bits [3:1] select a base test, bit 0 inverts it.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = (n == v) && !z;
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  task automatic idle();
    i_RST = 0; i_Stall_M = 0; i_Flush_M = 0; i_Valid_E = 0; i_Cond_E = 4'hE;
    i_ALU_Flags = 0; i_FlagWrite_E = 0; i_PCSrc_E = 0; i_RegWrite_E = 0;
    i_MemWrite_E = 0; i_ALU_Result = 0; i_WriteData_E = 0; i_WA3_E = 0;
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic cycle(input string tag);
    logic ex;
    #2;
    ex = i_Valid_E && ref_pass(i_Cond_E, m_flags);
    check_val({tag, "_condex"}, {31'b0, o_CondEx_E}, {31'b0, ex});
    check_val({tag, "_pcsrc"}, {31'b0, o_PCSrc_E}, {31'b0, ex && i_PCSrc_E});
    if (i_RST) begin
      m_flags = 0; m_rw = 0; m_mw = 0; m_res = 0; m_wd = 0; m_wa3 = 0;
    end else begin
      if (!i_Stall_M && ex) begin
        if (i_FlagWrite_E[1]) m_flags[3:2] = i_ALU_Flags[3:2];
        if (i_FlagWrite_E[0]) m_flags[1:0] = i_ALU_Flags[1:0];
      end
      if (i_Flush_M) begin
        m_rw = 0; m_mw = 0; m_res = 0; m_wd = 0; m_wa3 = 0;
      end else if (!i_Stall_M) begin
        m_rw = i_RegWrite_E && ex; m_mw = i_MemWrite_E && ex;
        m_res = i_ALU_Result; m_wd = i_WriteData_E; m_wa3 = i_WA3_E;
      end
    end
    @(posedge i_CLK);
    #1;
    check_val({tag, "_flags"}, {28'b0, o_Flags}, {28'b0, m_flags});
    check_val({tag, "_rw"}, {31'b0, o_RegWrite_M}, {31'b0, m_rw});
    check_val({tag, "_mw"}, {31'b0, o_MemWrite_M}, {31'b0, m_mw});
    check_val({tag, "_res"}, o_ALUResult_M, m_res);
    check_val({tag, "_wd"}, o_WriteData_M, m_wd);
    check_val({tag, "_wa3"}, {28'b0, o_WA3_M}, {28'b0, m_wa3});
  endtask

  task automatic set_flags(input logic [3:0] f);
    idle(); i_Valid_E = 1; i_Cond_E = 4'hE; i_FlagWrite_E = 2'b11; i_ALU_Flags = f;
    cycle("setf");
  endtask

  task automatic rand_inputs();
    i_RST = ($urandom_range(0, 49) == 0);
    i_Stall_M = ($urandom_range(0, 4) == 0);
    i_Flush_M = ($urandom_range(0, 7) == 0);
    i_Valid_E = ($urandom_range(0, 7) != 0);
    i_Cond_E = 4'($urandom); i_ALU_Flags = 4'($urandom); i_FlagWrite_E = 2'($urandom);
    i_PCSrc_E = 1'($urandom); i_RegWrite_E = 1'($urandom); i_MemWrite_E = 1'($urandom);
    i_ALU_Result = $urandom; i_WriteData_E = $urandom; i_WA3_E = 4'($urandom);
  endtask

  initial begin
    m_flags = 0; m_rw = 0; m_mw = 0; m_res = 0; m_wd = 0; m_wa3 = 0;
    idle();
    i_RST = 1;
    @(posedge i_CLK); #1;
    cycle("rst0");
    cycle("rst1");
    check_val("rst_flags", {28'b0, o_Flags}, 32'h0);
    i_RST = 0;

    // Flag set then test
    set_flags(4'b0100);
    check_val("t2_flags", {28'b0, o_Flags}, 32'h4);
    idle(); i_Valid_E = 1; i_Cond_E = 4'h0; i_RegWrite_E = 1; i_ALU_Result = 32'h1234;
    #2; check_val("t2_eq_condex", {31'b0, o_CondEx_E}, 32'h1);
    cycle("t2_eq");
    check_val("t2_eq_rw", {31'b0, o_RegWrite_M}, 32'h1);
    i_Cond_E = 4'h1;
    #2; check_val("t2_ne_condex", {31'b0, o_CondEx_E}, 32'h0);
    cycle("t2_ne");
    check_val("t2_ne_rw", {31'b0, o_RegWrite_M}, 32'h0);

    // Failed condition
    set_flags(4'b0000);
    idle(); i_Valid_E = 1; i_Cond_E = 4'h0; i_FlagWrite_E = 2'b11; i_ALU_Flags = 4'hF;
    i_MemWrite_E = 1; i_PCSrc_E = 1;
    #2; check_val("t3_pcsrc", {31'b0, o_PCSrc_E}, 32'h0);
    cycle("t3");
    check_val("t3_flags", {28'b0, o_Flags}, 32'h0);
    check_val("t3_mw", {31'b0, o_MemWrite_M}, 32'h0);

    // Partial update
    set_flags(4'b0011);
    idle(); i_Valid_E = 1; i_FlagWrite_E = 2'b10; i_ALU_Flags = 4'b1100;
    cycle("t4a");
    check_val("t4a_flags", {28'b0, o_Flags}, 32'hF);
    i_FlagWrite_E = 2'b01; i_ALU_Flags = 4'b0000;
    cycle("t4b");
    check_val("t4b_flags", {28'b0, o_Flags}, 32'hC);

    // Full condition sweep
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        idle(); i_Valid_E = 1; i_Cond_E = 4'(c); i_RegWrite_E = 1;
        cycle("sweep");
      end
    end

    // Stall / flush
    set_flags(4'b1010);
    idle(); i_Valid_E = 1; i_RegWrite_E = 1; i_ALU_Result = 32'hCAFE; i_WA3_E = 4'h7;
    cycle("t6_load");
    i_Stall_M = 1; i_FlagWrite_E = 2'b11; i_ALU_Flags = 4'b0101; i_ALU_Result = 32'hBEEF;
    cycle("t6_stall");
    check_val("t6_stall_flags", {28'b0, o_Flags}, 32'hA);
    check_val("t6_stall_res", o_ALUResult_M, 32'hCAFE);
    i_Flush_M = 1;
    cycle("t6_fs");
    check_val("t6_fs_rw", {31'b0, o_RegWrite_M}, 32'h0);
    check_val("t6_fs_flags", {28'b0, o_Flags}, 32'hA);
    i_Stall_M = 0; i_RST = 1;
    cycle("t6_rf");
    check_val("t6_rf_flags", {28'b0, o_Flags}, 32'h0);

    // Random traffic, with a 2-cycle reset pulse mid-stream
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      if (i == 700 || i == 701) i_RST = 1;
      cycle("rand");
      if (i == 701) begin
        check_val("midrst_flags", {28'b0, o_Flags}, 32'h0);
        check_val("midrst_rw", {31'b0, o_RegWrite_M}, 32'h0);
        check_val("midrst_res", o_ALUResult_M, 32'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
